// File: rtl/parking_gate_ctrl.sv
// Gate-lane controller: synchronizes entrance/exit presence sensors, runs one
// gate FSM per lane, and keeps a saturating lot occupancy count with flags.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 3,
  parameter int CNT_W       = 2,
  parameter int HOLD_CYC    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ent_sense,
  input  logic             ext_sense,
  output logic             ent_open,
  output logic             ext_open,
  output logic             ent_pulse,
  output logic             ext_pulse,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {ENT_IDLE, ENT_OPEN, ENT_DENY, ENT_HOLD} ent_state_t;
  typedef enum logic [1:0] {EXT_IDLE, EXT_OPEN, EXT_HOLD} ext_state_t;

  logic [SYNC_STAGES-1:0] ent_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   s_ent;
  logic                   s_ext;
  ent_state_t             ent_state;
  ext_state_t             ext_state;
  logic [HOLD_W-1:0]      ent_cnt;
  logic [HOLD_W-1:0]      ext_cnt;
  logic                   ent_evt;
  logic                   ext_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_sync <= '0;
      ext_sync <= '0;
    end else begin
      ent_sync <= {ent_sync[SYNC_STAGES-2:0], ent_sense};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_sense};
    end
  end

  assign s_ent = ent_sync[SYNC_STAGES-1];
  assign s_ext = ext_sync[SYNC_STAGES-1];

  // A car is counted on the edge its lane leaves OPEN; pulses and occupancy share this.
  assign ent_evt = (ent_state == ENT_OPEN) && !s_ent;
  assign ext_evt = (ext_state == EXT_OPEN) && !s_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_state <= ENT_IDLE;
      ent_cnt   <= '0;
      ent_open  <= 1'b0;
      ent_pulse <= 1'b0;
    end else begin
      ent_pulse <= 1'b0;
      case (ent_state)
        ENT_IDLE: begin
          if (s_ent) begin
            ent_state <= full ? ENT_DENY : ENT_OPEN;
            ent_open  <= !full;
          end
        end
        ENT_OPEN: begin
          if (!s_ent) begin
            ent_state <= ENT_HOLD;
            ent_cnt   <= HOLD_LOAD;
            ent_pulse <= 1'b1;
          end
        end
        ENT_DENY: begin
          if (!s_ent) ent_state <= ENT_IDLE;
        end
        ENT_HOLD: begin
          // full here already reflects the count from the car that just entered
          if (s_ent) begin
            ent_state <= full ? ENT_DENY : ENT_OPEN;
            ent_open  <= !full;
          end else if (ent_cnt == '0) begin
            ent_state <= ENT_IDLE;
            ent_open  <= 1'b0;
          end else begin
            ent_cnt <= ent_cnt - HOLD_W'(1);
          end
        end
        default: begin
          ent_state <= ENT_IDLE;
          ent_open  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_state <= EXT_IDLE;
      ext_cnt   <= '0;
      ext_open  <= 1'b0;
      ext_pulse <= 1'b0;
    end else begin
      ext_pulse <= 1'b0;
      case (ext_state)
        EXT_IDLE: begin
          if (s_ext) begin
            ext_state <= EXT_OPEN;
            ext_open  <= 1'b1;
          end
        end
        EXT_OPEN: begin
          if (!s_ext) begin
            ext_state <= EXT_HOLD;
            ext_cnt   <= HOLD_LOAD;
            ext_pulse <= 1'b1;
          end
        end
        EXT_HOLD: begin
          if (s_ext) begin
            ext_state <= EXT_OPEN;
          end else if (ext_cnt == '0) begin
            ext_state <= EXT_IDLE;
            ext_open  <= 1'b0;
          end else begin
            ext_cnt <= ext_cnt - HOLD_W'(1);
          end
        end
        default: begin
          ext_state <= EXT_IDLE;
          ext_open  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
      err       <= 1'b0;
    end else begin
      case ({ent_evt, ext_evt})
        2'b10: if (occupancy != CAP) occupancy <= occupancy + CNT_W'(1);
        2'b01: begin
          if (occupancy == '0) err <= 1'b1;
          else occupancy <= occupancy - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: expected values are queued with the
// cycle they are due and compared at the falling edge of that cycle.
module tb_parking_gate_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ent_sense = 1'b0;
  logic             ext_sense = 1'b0;
  logic             ent_open;
  logic             ext_open;
  logic             ent_pulse;
  logic             ext_pulse;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {S_ENT_OPEN, S_EXT_OPEN, S_ENT_PULSE, S_EXT_PULSE,
                    S_OCC, S_FULL, S_EMPTY, S_ERR} sig_e;
  typedef struct {
    int    due;
    sig_e  sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  parking_gate_ctrl #(
    .CAPACITY   (3),
    .CNT_W      (CNT_W),
    .HOLD_CYC   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ent_sense (ent_sense),
    .ext_sense (ext_sense),
    .ent_open  (ent_open),
    .ext_open  (ext_open),
    .ent_pulse (ent_pulse),
    .ext_pulse (ext_pulse),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ENT_OPEN:  return {31'b0, ent_open};
      S_EXT_OPEN:  return {31'b0, ext_open};
      S_ENT_PULSE: return {31'b0, ent_pulse};
      S_EXT_PULSE: return {31'b0, ext_pulse};
      S_OCC:       return {30'b0, occupancy};
      S_FULL:      return {31'b0, full};
      S_EMPTY:     return {31'b0, empty};
      default:     return {31'b0, err};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_at(input string tag, input sig_e s, input int val, input int d);
    sb.push_back('{cyc + d, s, val, tag});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          chk(sb[i].tag, observe(sb[i].sig), sb[i].val);
          sb.delete(i);
        end
      end
    end
  endtask

  // Sensor seen by the FSM three samples after it is driven; the gate closes
  // four cycles after the pulse.
  task automatic car_entry(input int hold, input int occ_before, input string tag);
    ent_sense = 1'b1;
    expect_at({tag, "_open_pre"}, S_ENT_OPEN, 0, 2);
    expect_at({tag, "_open_rise"}, S_ENT_OPEN, 1, 3);
    step(hold);
    ent_sense = 1'b0;
    expect_at({tag, "_pulse_pre"}, S_ENT_PULSE, 0, 2);
    expect_at({tag, "_pulse"}, S_ENT_PULSE, 1, 3);
    expect_at({tag, "_pulse_post"}, S_ENT_PULSE, 0, 4);
    expect_at({tag, "_occ_pre"}, S_OCC, occ_before, 2);
    expect_at({tag, "_occ_post"}, S_OCC, occ_before + 1, 3);
    expect_at({tag, "_open_hold"}, S_ENT_OPEN, 1, 6);
    expect_at({tag, "_open_fall"}, S_ENT_OPEN, 0, 7);
    step(8);
  endtask

  task automatic car_exit(input int hold, input int occ_before, input string tag);
    ext_sense = 1'b1;
    expect_at({tag, "_open_pre"}, S_EXT_OPEN, 0, 2);
    expect_at({tag, "_open_rise"}, S_EXT_OPEN, 1, 3);
    step(hold);
    ext_sense = 1'b0;
    expect_at({tag, "_pulse_pre"}, S_EXT_PULSE, 0, 2);
    expect_at({tag, "_pulse"}, S_EXT_PULSE, 1, 3);
    expect_at({tag, "_pulse_post"}, S_EXT_PULSE, 0, 4);
    expect_at({tag, "_occ_pre"}, S_OCC, occ_before, 2);
    expect_at({tag, "_occ_post"}, S_OCC, (occ_before == 0) ? 0 : occ_before - 1, 3);
    if (occ_before == 0) expect_at({tag, "_err"}, S_ERR, 1, 3);
    expect_at({tag, "_open_hold"}, S_EXT_OPEN, 1, 6);
    expect_at({tag, "_open_fall"}, S_EXT_OPEN, 0, 7);
    step(8);
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_ent_open", observe(S_ENT_OPEN), 0);
    chk("rst_ext_open", observe(S_EXT_OPEN), 0);
    chk("rst_ent_pulse", observe(S_ENT_PULSE), 0);
    chk("rst_ext_pulse", observe(S_EXT_PULSE), 0);
    chk("rst_occ", observe(S_OCC), 0);
    chk("rst_full", observe(S_FULL), 0);
    chk("rst_empty", observe(S_EMPTY), 1);
    chk("rst_err", observe(S_ERR), 0);
    rst = 1'b1;
    for (int d = 1; d <= 10; d++) begin
      expect_at("idle_occ", S_OCC, 0, d);
      expect_at("idle_empty", S_EMPTY, 1, d);
      expect_at("idle_ent_open", S_ENT_OPEN, 0, d);
      expect_at("idle_ext_pulse", S_EXT_PULSE, 0, d);
    end
    step(10);

    // Fill the lot
    car_entry(5, 0, "ent1");
    chk("ent1_empty", observe(S_EMPTY), 0);
    car_entry(3, 1, "ent2");
    car_entry(3, 2, "ent3");
    chk("lot_full", observe(S_FULL), 1);
    chk("lot_full_occ", observe(S_OCC), 3);

    // Fourth car is denied
    ent_sense = 1'b1;
    for (int d = 1; d <= 10; d++) begin
      expect_at("deny_open", S_ENT_OPEN, 0, d);
      expect_at("deny_pulse", S_ENT_PULSE, 0, d);
      expect_at("deny_occ", S_OCC, 3, d);
    end
    step(6);
    ent_sense = 1'b0;
    step(5);

    // Empty the lot, then one exit too many
    car_exit(3, 3, "ext1");
    chk("ext1_full_clear", observe(S_FULL), 0);
    car_exit(3, 2, "ext2");
    car_exit(3, 1, "ext3");
    chk("no_err_yet", observe(S_ERR), 0);
    chk("empty_again", observe(S_EMPTY), 1);
    car_exit(3, 0, "ext_empty");
    car_entry(3, 0, "ent_after_err");
    chk("err_sticky", observe(S_ERR), 1);

    // Reset clears err
    rst = 1'b0;
    #1;
    chk("rst2_err", observe(S_ERR), 0);
    chk("rst2_occ", observe(S_OCC), 0);
    step(2);
    rst = 1'b1;
    step(2);

    // Simultaneous entry and exit at occupancy 2
    car_entry(3, 0, "sim_pre1");
    car_entry(3, 1, "sim_pre2");
    ent_sense = 1'b1;
    ext_sense = 1'b1;
    expect_at("sim_ent_open", S_ENT_OPEN, 1, 3);
    expect_at("sim_ext_open", S_EXT_OPEN, 1, 3);
    step(4);
    ent_sense = 1'b0;
    ext_sense = 1'b0;
    expect_at("sim_ent_pulse", S_ENT_PULSE, 1, 3);
    expect_at("sim_ext_pulse", S_EXT_PULSE, 1, 3);
    expect_at("sim_occ", S_OCC, 2, 3);
    expect_at("sim_occ_after", S_OCC, 2, 4);
    expect_at("sim_err", S_ERR, 0, 4);
    step(8);

    // Tailgate: re-trigger during HOLD keeps the gate open
    car_exit(3, 2, "tail_pre");
    ent_sense = 1'b1;
    for (int d = 3; d <= 14; d++) expect_at("tail_open_cont", S_ENT_OPEN, 1, d);
    step(3);
    ent_sense = 1'b0;
    expect_at("tail_pulse1", S_ENT_PULSE, 1, 3);
    expect_at("tail_occ1", S_OCC, 2, 3);
    step(3);
    ent_sense = 1'b1;
    expect_at("tail_pulse_gap", S_ENT_PULSE, 0, 1);
    step(4);
    ent_sense = 1'b0;
    expect_at("tail_pulse2", S_ENT_PULSE, 1, 3);
    expect_at("tail_occ2", S_OCC, 3, 3);
    expect_at("tail_full", S_FULL, 1, 3);
    step(4);

    // Reset while the gate is open
    chk("midrst_pre_open", observe(S_ENT_OPEN), 1);
    rst = 1'b0;
    #1;
    chk("midrst_open", observe(S_ENT_OPEN), 0);
    chk("midrst_occ", observe(S_OCC), 0);
    chk("midrst_full", observe(S_FULL), 0);
    chk("midrst_empty", observe(S_EMPTY), 1);
    step(2);
    rst = 1'b1;
    step(2);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Gate-lane controller feeding the parking-lot top level.
- Takes the raw entrance and exit presence sensors.
- Drives the entrance and exit gate-open outputs.
- Produces one-cycle car-entered / car-exited pulses and a saturating lot occupancy count with full/empty flags.
- Downstream, the top level consumes the occupancy for the lot-space HEX display, uses full for the "lot full" LED, and logs the pulses into the hourly totals.

Parameters:
- CAPACITY, 3, number of parking spaces; occupancy saturates here.
- CNT_W, 2, width of occupancy; must satisfy 2**CNT_W > CAPACITY.
- HOLD_CYC, 4, cycles a gate stays open after the car clears the sensor; must be ≥ 1.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each sensor input; must be ≥ 2.

Ports:
- clk, input, 1, system clock (CLOCK_50).
- rst, input, 1, asynchronous active-low reset; rst=0 resets all state.
- ent_sense, input, 1, raw entrance presence sensor (1 = car present), asynchronous.
- ext_sense, input, 1, raw exit presence sensor (1 = car present), asynchronous.
- ent_open, output, 1, entrance gate open command, registered.
- ext_open, output, 1, exit gate open command, registered.
- ent_pulse, output, 1, one-cycle pulse per counted entry.
- ext_pulse, output, 1, one-cycle pulse per counted exit.
- occupancy, output, CNT_W, cars currently in the lot.
- full, output, 1, occupancy == CAPACITY.
- empty, output, 1, occupancy == 0.
- err, output, 1, sticky: an exit was counted while empty.

Behaviour:
Reset (rst=0, asynchronous)
- Synchronizers clear to 0; both lane FSMs go to IDLE.
- occupancy=0, ent_open=ext_open=0, ent_pulse=ext_pulse=0, err=0.
- full=0 and empty=1 (these two are combinational decodes of occupancy).
- Deassertion is taken at the next clk edge; no sensor event is inferred from the reset release itself.

Synchronization
- Each sensor passes through SYNC_STAGES flops; s_ent and s_ext are the final-stage values.
- With SYNC_STAGES=2, a raw edge set up before edge N is seen by the FSM at edge N+2.
- All outputs change on that same edge, i.e. 2 cycles of latency from raw input to output.

Entrance FSM (states IDLE, OPEN, DENY, HOLD; ent_open=1 in OPEN and HOLD only)
- IDLE: s_ent & ~full -> OPEN; s_ent & full -> DENY; else stay.
- OPEN: ~s_ent -> HOLD, load hold counter with HOLD_CYC-1, assert ent_pulse this cycle, occupancy+1.
- DENY: gate stays closed; ~s_ent -> IDLE; no count.
- HOLD: s_ent -> OPEN if ~full, else DENY (full evaluated on the post-increment value); counter==0 -> IDLE; else decrement.

Exit FSM (states IDLE, OPEN, HOLD; never denies)
- Same as the entrance FSM with DENY removed; ext_pulse fires on the OPEN->HOLD transition.
- If occupancy==0 at that edge: occupancy stays 0 and err sets (sticky until reset).

Occupancy arithmetic (single registered update per cycle)
- ent_pulse & ext_pulse on the same edge -> net 0; occupancy unchanged, err unchanged.
- ent only -> +1, saturating at CAPACITY. Not reachable from the FSM; stated as defensive.
- ext only -> -1, saturating at 0 with err set.
- ent_pulse is high for exactly one cycle per entry, and ext_pulse for exactly one cycle per exit.

Glitches and reset mid-operation
- A sensor glitch shorter than one clk period may be missed; the FSM never produces more than one pulse per OPEN visit.
- Reset asserted mid-operation (e.g. gate OPEN) closes the gate immediately and loses the count.

Test Plan:
- Reset with both sensors 0 -> all outputs 0 except empty=1; release, idle 10 cycles -> no change.
- ent_sense 1 for 5 cycles then 0 (HOLD_CYC=4):
  - ent_open rises 2 edges after the sensor rise.
  - ent_pulse is a single cycle 2 edges after the sensor fall; occupancy 0->1 on that same edge.
  - ent_open falls 4 cycles after the pulse.
- Three entries -> occupancy=3, full=1, and the "lot full" LED drives high. A fourth ent_sense held 6 cycles -> ent_open stays 0, no ent_pulse, occupancy stays 3; sensor drops -> IDLE.
- Exit from empty: ext_sense pulse at occupancy 0 -> ext_open opens, ext_pulse fires, occupancy stays 0, err=1 and stays 1 through later entries until rst=0.
- Simultaneous events: occupancy=2, both sensors released on the same cycle so both pulses land on the same edge -> occupancy stays 2.
- Tailgate and mid-operation reset:
  - Re-assert ent_sense during HOLD with occupancy=1 -> returns to OPEN, ent_open stays 1 continuously, second pulse gives occupancy=3.
  - Assert rst=0 while ent_open=1 -> ent_open=0 and occupancy=0 immediately, without waiting for a clock edge.
